multi_edge_detector: RTL and testbench

Parametrised multi-channel edge detector that generalises the single-bit rising-edge pulse generator. Each channel synchronises an asynchronous input, debounces it, and emits a one-cycle registered event pulse on rising, falling or both edges as selected per channel at run time. Sticky per-channel flags and a combined event output let a controller or the CNN control FSM poll or interrupt on start/done/trigger lines without missing short pulses.

---
 rtl/multi_edge_detector_if.sv | 25 ++
 rtl/multi_edge_detector.sv | 107 ++++++++++
 tb/tb_multi_edge_detector.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_edge_detector_if.sv
// Bus bundle for multi_edge_detector: raw inputs, per-channel mode and
// sticky-clear from the controller, and debounced level / event outputs back.
interface multi_edge_detector_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   sig;      // raw asynchronous input per channel
    logic [2*WIDTH-1:0] mode;     // per channel: 00 off, 01 rise, 10 fall, 11 both
    logic [WIDTH-1:0]   clr;      // level-sensitive sticky clear
    logic [WIDTH-1:0]   level;    // debounced level
    logic [WIDTH-1:0]   evt;      // one-cycle registered event pulse
    logic [WIDTH-1:0]   sticky;   // latched event flag
    logic               any_evt;  // OR of evt

    // Controller side: drives inputs, observes results.
    modport master (
        output sig, mode, clr,
        input  level, evt, sticky, any_evt
    );

    // Detector side.
    modport slave (
        input  sig, mode, clr,
        output level, evt, sticky, any_evt
    );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per channel a synchroniser, a debounce
// counter, and a registered event pulse on rising/falling/both edges of the
// debounced level, with sticky flags and a combined event output.
module multi_edge_detector #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_edge_detector_if.slave bus
);
    localparam int             CW      = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE - 1);

    // Synchroniser stages; stage SYNC_STAGES-1 is the safe, synchronised copy.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] syn;

    // Debounce counters per channel and the debounced level.
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;

    // Event qualification and sticky flags.
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt_d;
    logic [WIDTH-1:0] evt_q;
    logic [WIDTH-1:0] sticky_d;
    logic [WIDTH-1:0] sticky_q;

    assign syn = sync_q[SYNC_STAGES-1];

    // Shift each raw input through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage capture the
            // previous stage's old value, so the chain really is SYNC_STAGES deep.
            sync_q[0] <= bus.sig;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Debounce: count consecutive mismatch cycles, flip level when the count
    // reaches DEBOUNCE; any return to the current level restarts the count.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit (no latches).
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (syn[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = syn[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Qualify level flips against the per-channel mode, then update sticky;
    // a new event beats a same-cycle clear.
    always_comb begin
        rise  = level_d & ~level_q;
        fall  = ~level_d & level_q;
        evt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            evt_d[i] = (rise[i] & bus.mode[2*i]) | (fall[i] & bus.mode[2*i+1]);
        end
        sticky_d = evt_d | (sticky_q & ~bus.clr);
    end

    // Register debounce counters, level, event pulse and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is control state, not storage, so it is
            // reset along with everything else to discard pending counts.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q  <= '0;
            evt_q    <= '0;
            sticky_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q  <= level_d;
            evt_q    <= evt_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.level   = level_q;
    assign bus.evt     = evt_q;
    assign bus.sticky  = sticky_q;
    assign bus.any_evt = |evt_q;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector with default parameters
// (WIDTH=4, SYNC_STAGES=2, DEBOUNCE=4): a level flip appears after the
// sixth rising edge counting the first sampling edge as edge 0.
module tb_multi_edge_detector;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multi_edge_detector_if #(.WIDTH(4)) bus ();

    multi_edge_detector #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] sig;
        logic [7:0] mode;
        logic [3:0] clr;
        logic [3:0] level;
        logic [3:0] evt;
        logic [3:0] sticky;
        logic       any;
    } vec_t;

    vec_t vecs [24];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [3:0] s, input logic [7:0] m, input logic [3:0] c);
        bus.sig  = s;
        bus.mode = m;
        bus.clr  = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int k, output logic [3:0] evt_or);
        evt_or = '0;
        for (int j = 0; j < k; j++) begin
            tick();
            evt_or |= bus.evt;
        end
    endtask

    // Tick until an event appears (bounded); n = ticks taken, 21 if none.
    task automatic until_evt(output int n, output logic [3:0] ev, output logic any);
        n = 21; ev = '0; any = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (bus.evt != 0) begin
                n = j; ev = bus.evt; any = bus.any_evt;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic vset(input int k, input logic [3:0] s, input logic [7:0] m, input logic [3:0] c,
                        input logic [3:0] l, input logic [3:0] e, input logic [3:0] st);
        vecs[k] = '{sig: s, mode: m, clr: c, level: l, evt: e, sticky: st, any: |e};
    endtask

    initial begin
        int         n;
        logic [3:0] ev;
        logic [3:0] eo;
        logic       an;

        // Vector k: inputs applied before edge k, outputs checked after it.
        for (int k = 0; k < 5; k++) vset(k, 4'b0001, 8'h55, 4'h0, 4'h0, 4'h0, 4'h0);
        vset(5,  4'b0001, 8'h55, 4'h0, 4'h1, 4'h1, 4'h1);   // rise on ch0
        vset(6,  4'b0001, 8'h55, 4'h0, 4'h1, 4'h0, 4'h1);   // pulse gone, sticky held
        for (int k = 7; k < 12; k++) vset(k, 4'b0000, 8'h57, 4'h0, 4'h1, 4'h0, 4'h1);
        vset(12, 4'b0000, 8'h57, 4'h1, 4'h0, 4'h1, 4'h1);   // fall evt + clr: set wins
        vset(13, 4'b0000, 8'h57, 4'h1, 4'h0, 4'h0, 4'h0);   // clr alone clears
        vset(14, 4'b0000, 8'h55, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int k = 15; k < 20; k++) vset(k, 4'b1111, 8'h55, 4'h0, 4'h0, 4'h0, 4'h0);
        vset(20, 4'b1111, 8'h55, 4'h0, 4'hF, 4'hF, 4'hF);   // all channels at once
        vset(21, 4'b1111, 8'h55, 4'h0, 4'hF, 4'h0, 4'hF);
        vset(22, 4'b1111, 8'h55, 4'hF, 4'hF, 4'h0, 4'h0);
        vset(23, 4'b1111, 8'h55, 4'h0, 4'hF, 4'h0, 4'h0);

        apply(4'h0, 8'h00, 4'h0);
        rst = 1'b1;
        #3;
        check("reset_level",  {28'd0, bus.level},  32'd0);
        check("reset_evt",    {28'd0, bus.evt},    32'd0);
        check("reset_sticky", {28'd0, bus.sticky}, 32'd0);
        check("reset_any",    {31'd0, bus.any_evt}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int k = 0; k < 24; k++) begin
            apply(vecs[k].sig, vecs[k].mode, vecs[k].clr);
            tick();
            check($sformatf("v%0d_level", k),  {28'd0, bus.level},   {28'd0, vecs[k].level});
            check($sformatf("v%0d_evt", k),    {28'd0, bus.evt},     {28'd0, vecs[k].evt});
            check($sformatf("v%0d_sticky", k), {28'd0, bus.sticky},  {28'd0, vecs[k].sticky});
            check($sformatf("v%0d_any", k),    {31'd0, bus.any_evt}, {31'd0, vecs[k].any});
        end

        // ch1 falling-only: rise suppressed, fall reported.
        apply(4'h0, 8'h00, 4'h0);
        do_reset();
        apply(4'b0010, 8'b0000_1000, 4'h0);
        run_ticks(8, eo);
        check("ch1_rise_suppressed", {28'd0, eo}, 32'd0);
        check("ch1_level_high", {28'd0, bus.level}, 32'h2);
        apply(4'b0000, 8'b0000_1000, 4'h0);
        until_evt(n, ev, an);
        check("ch1_fall_latency", n, 6);
        check("ch1_fall_evt", {28'd0, ev}, 32'h2);
        check("ch1_fall_any", {31'd0, an}, 32'd1);
        check("ch1_fall_sticky", {28'd0, bus.sticky}, 32'h2);
        tick();
        check("ch1_evt_one_cycle", {28'd0, bus.evt}, 32'd0);
        // ch1 both edges.
        apply(4'b0010, 8'b0000_1100, 4'h0);
        until_evt(n, ev, an);
        check("ch1_both_rise_latency", n, 6);
        check("ch1_both_rise_evt", {28'd0, ev}, 32'h2);
        apply(4'b0000, 8'b0000_1100, 4'h0);
        until_evt(n, ev, an);
        check("ch1_both_fall_latency", n, 6);
        check("ch1_both_fall_evt", {28'd0, ev}, 32'h2);

        // Glitch on ch2: 3 cycles filtered, 4 cycles accepted.
        apply(4'h0, 8'h00, 4'h0);
        do_reset();
        apply(4'b0100, 8'b0001_0000, 4'h0);
        run_ticks(3, eo);
        apply(4'b0000, 8'b0001_0000, 4'h0);
        run_ticks(12, ev);
        check("glitch3_evt", {28'd0, eo | ev}, 32'd0);
        check("glitch3_level", {28'd0, bus.level}, 32'd0);
        apply(4'b0100, 8'b0001_0000, 4'h0);
        run_ticks(4, eo);
        check("glitch4_no_early_evt", {28'd0, eo}, 32'd0);
        apply(4'b0000, 8'b0001_0000, 4'h0);
        until_evt(n, ev, an);
        check("glitch4_latency", n, 2);
        check("glitch4_evt", {28'd0, ev}, 32'h4);
        run_ticks(12, eo);
        check("glitch4_fall_no_evt", {28'd0, eo}, 32'd0);
        check("glitch4_level_back", {28'd0, bus.level}, 32'd0);

        // Reset mid-count: sticky[2] is still set from the glitch test.
        apply(4'b0001, 8'h55, 4'h0);
        run_ticks(4, eo);
        check("midrst_pre_sticky", {28'd0, bus.sticky}, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_level",  {28'd0, bus.level},  32'd0);
        check("midrst_evt",    {28'd0, bus.evt},    32'd0);
        check("midrst_sticky", {28'd0, bus.sticky}, 32'd0);
        check("midrst_any",    {31'd0, bus.any_evt}, 32'd0);
        apply(4'b0000, 8'h55, 4'h0);
        tick();
        tick();
        rst = 1'b0;
        run_ticks(10, eo);
        check("midrst_no_evt_after", {28'd0, eo}, 32'd0);
        check("midrst_level_after", {28'd0, bus.level}, 32'd0);

        // Disabled ch3: level follows, no event or sticky.
        apply(4'b1000, 8'h00, 4'h0);
        run_ticks(7, eo);
        check("off_level_up", {28'd0, bus.level}, 32'h8);
        apply(4'b0000, 8'h00, 4'h0);
        run_ticks(7, ev);
        check("off_level_down", {28'd0, bus.level}, 32'd0);
        check("off_no_evt", {28'd0, eo | ev}, 32'd0);
        check("off_no_sticky", {28'd0, bus.sticky}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
